// File: rtl/rbfu_out_xbar_pkg.sv
// rbfu_out_xbar_pkg: shared build constants and helpers for the RBFU output crossbar.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rbfu_out_xbar_pkg;

  // Build-wide defaults: butterflies per stage, lane width, select width, RBFU pipe depth
  localparam int RBFU_P          = 2;
  localparam int RBFU_DATA_WIDTH = 16;
  localparam int RBFU_MAP        = 3;
  localparam int RBFU_L          = 2;

  // Width of the control word carried through the select delay line:
  // {mode, sel_valid, sel_mask[LANES], sel_bus[LANES*SEL_W]}
  function automatic int ctrl_width(input int lanes, input int sel_w);
    return lanes * sel_w + lanes + 2;
  endfunction

endpackage

// File: rtl/rbfu_out_xbar_shift.sv
// rbfu_out_xbar_shift: fixed-depth shift register used as the select delay line.
// Latency: SHIFT cycles from d to q.
// Backpressure: none; shifts every cycle, reset drops every in-flight word.
module rbfu_out_xbar_shift #(
  parameter int WIDTH = 1,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SHIFT];
  logic [WIDTH-1:0] stage_d [SHIFT];

  // Stage 0 takes the input, every later stage takes its predecessor
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SHIFT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Advance the whole line each cycle; reset clears every stage at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SHIFT; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SHIFT; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SHIFT-1];

endmodule

// File: rtl/rbfu_out_xbar.sv
// rbfu_out_xbar: reorders RBFU output lanes into memory write lanes with per-lane enables.
// Latency: LAT+1 cycles sel_valid -> d_valid, 1 cycle bf_valid -> d_valid.
// Backpressure: none; accepts a new select and data beat every cycle.
module rbfu_out_xbar
  import rbfu_out_xbar_pkg::*;
#(
  parameter int LANES      = 2 * RBFU_P,
  parameter int DATA_WIDTH = RBFU_DATA_WIDTH,
  parameter int SEL_W      = RBFU_MAP,
  parameter int LAT        = RBFU_L + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*SEL_W-1:0]      sel_bus,
  input  logic [LANES-1:0]            sel_mask,
  input  logic                        sel_valid,
  input  logic                        mode,
  input  logic [LANES*DATA_WIDTH-1:0] bf_out_bus,
  input  logic                        bf_valid,
  output logic [LANES*DATA_WIDTH-1:0] d_in_bus,
  output logic [LANES-1:0]            we_bus,
  output logic                        d_valid,
  input  logic                        err_clr,
  output logic                        align_err,
  output logic                        conflict_err,
  output logic [15:0]                 beat_cnt
);

  localparam int          IDX_W   = $clog2(LANES);
  localparam int          CW      = ctrl_width(LANES, SEL_W);
  localparam logic [31:0] LANES_U = LANES;

  // Select-side control word, delayed to line up with the matching data beat
  logic [CW-1:0]          ctrl_in;
  logic [CW-1:0]          ctrl_dly;
  logic [LANES*SEL_W-1:0] dly_sel;
  logic [LANES-1:0]       dly_mask;
  logic                   dly_valid;
  logic                   dly_mode;

  assign ctrl_in = {mode, sel_valid, sel_mask, sel_bus};

  rbfu_out_xbar_shift #(
    .WIDTH (CW),
    .SHIFT (LAT)
  ) u_ctrl_dly (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_in),
    .q   (ctrl_dly)
  );

  assign {dly_mode, dly_valid, dly_mask, dly_sel} = ctrl_dly;

  // Per-lane decode and crossbar signals
  logic [DATA_WIDTH-1:0] bf_lane  [LANES];
  logic [IDX_W-1:0]      lane_src [LANES];
  logic [LANES-1:0]      lane_oor;
  logic                  dup_hit;
  logic                  beat_ok;
  logic                  align_evt;
  logic                  conflict_evt;

  // Registered outputs and their next-state values
  logic [LANES*DATA_WIDTH-1:0] d_in_q, d_in_d;
  logic [LANES-1:0]            we_q, we_d;
  logic                        d_valid_q, d_valid_d;
  logic                        align_err_q, align_err_d;
  logic                        conflict_err_q, conflict_err_d;
  logic [15:0]                 beat_cnt_q, beat_cnt_d;

  // Split the flat RBFU output bus into addressable lanes
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      bf_lane[j] = bf_out_bus[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Resolve each destination's source: its select in permute mode, itself in bypass
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_oor[k] = 1'b0;
      lane_src[k] = IDX_W'(k);
      if (!dly_mode) begin
        lane_oor[k] = 32'(dly_sel[k*SEL_W +: SEL_W]) >= LANES_U;
        lane_src[k] = dly_sel[k*SEL_W +: IDX_W];
      end
    end
  end

  // Detect two enabled, in-range destinations sharing one source (permute mode only)
  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (!dly_mode && dly_mask[i] && dly_mask[j] && !lane_oor[i] && !lane_oor[j] &&
            (lane_src[i] == lane_src[j])) begin
          dup_hit = 1'b1;
        end
      end
    end
  end

  // Crossbar, enables, error events and counter next state.
  // An out-of-range select only counts as an error on an enabled lane; a
  // disabled lane's select is don't-care.
  always_comb begin
    beat_ok      = dly_valid & bf_valid;
    align_evt    = dly_valid ^ bf_valid;
    conflict_evt = beat_ok & ~dly_mode & (dup_hit | (|(lane_oor & dly_mask)));

    d_in_d = '0;
    we_d   = '0;
    if (beat_ok) begin
      for (int k = 0; k < LANES; k++) begin
        if (dly_mask[k] && !lane_oor[k]) begin
          d_in_d[k*DATA_WIDTH +: DATA_WIDTH] = bf_lane[lane_src[k]];
          we_d[k]                            = 1'b1;
        end
      end
    end

    d_valid_d      = beat_ok;
    beat_cnt_d     = beat_cnt_q + {15'd0, beat_ok};
    // A new event in the same cycle as err_clr keeps the flag set
    align_err_d    = align_evt | (align_err_q & ~err_clr);
    conflict_err_d = conflict_evt | (conflict_err_q & ~err_clr);
  end

  // Output, sticky-flag and beat-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_in_q         <= '0;
      we_q           <= '0;
      d_valid_q      <= 1'b0;
      align_err_q    <= 1'b0;
      conflict_err_q <= 1'b0;
      beat_cnt_q     <= '0;
    end else begin
      d_in_q         <= d_in_d;
      we_q           <= we_d;
      d_valid_q      <= d_valid_d;
      align_err_q    <= align_err_d;
      conflict_err_q <= conflict_err_d;
      beat_cnt_q     <= beat_cnt_d;
    end
  end

  assign d_in_bus     = d_in_q;
  assign we_bus       = we_q;
  assign d_valid      = d_valid_q;
  assign align_err    = align_err_q;
  assign conflict_err = conflict_err_q;
  assign beat_cnt     = beat_cnt_q;

endmodule

// File: tb/tb_rbfu_out_xbar.sv
// tb_rbfu_out_xbar: scoreboard bench for rbfu_out_xbar with LANES=4, LAT=3, DATA_WIDTH=16.
// Latency: expects data LAT+1 cycles after the select beat.
// Backpressure: none exercised; the DUT has none.
module tb_rbfu_out_xbar;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int SW    = 3;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [LANES*SW-1:0]   sel_bus = '0;
  logic [LANES-1:0]      sel_mask = '0;
  logic                  sel_valid = 1'b0;
  logic                  mode = 1'b0;
  logic [LANES*DW-1:0]   bf_out_bus = '0;
  logic                  bf_valid = 1'b0;
  logic                  err_clr = 1'b0;
  logic [LANES*DW-1:0]   d_in_bus;
  logic [LANES-1:0]      we_bus;
  logic                  d_valid;
  logic                  align_err;
  logic                  conflict_err;
  logic [15:0]           beat_cnt;

  typedef struct packed {
    logic [LANES*DW-1:0] d;
    logic [LANES-1:0]    we;
  } beat_t;

  typedef struct packed {
    logic [LANES*SW-1:0] sel;
    logic [LANES-1:0]    mask;
    logic                sv;
    logic                md;
    logic [LANES*DW-1:0] bf;
    logic                bv;
    logic                clr;
  } stim_t;

  beat_t exp_q[$];
  int    checks     = 0;
  int    failures   = 0;
  int    exp_beats  = 0;

  rbfu_out_xbar #(
    .LANES      (LANES),
    .DATA_WIDTH (DW),
    .SEL_W      (SW),
    .LAT        (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_bus      (sel_bus),
    .sel_mask     (sel_mask),
    .sel_valid    (sel_valid),
    .mode         (mode),
    .bf_out_bus   (bf_out_bus),
    .bf_valid     (bf_valid),
    .d_in_bus     (d_in_bus),
    .we_bus       (we_bus),
    .d_valid      (d_valid),
    .err_clr      (err_clr),
    .align_err    (align_err),
    .conflict_err (conflict_err),
    .beat_cnt     (beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference behaviour: destination k takes source sel_k (or k in bypass) when enabled and in range
  function automatic beat_t model(input logic [LANES*SW-1:0] sel, input logic [LANES-1:0] mask,
                                  input logic md, input logic [LANES*DW-1:0] bf);
    beat_t r;
    int    s;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      s = md ? k : int'(sel[k*SW +: SW]);
      if (mask[k] && s < LANES) begin
        r.d[k*DW +: DW] = bf[s*DW +: DW];
        r.we[k]         = 1'b1;
      end
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, then return inputs to idle; outputs are read 1 time unit after the edge
  task automatic apply(input stim_t s);
    sel_bus    = s.sel;
    sel_mask   = s.mask;
    sel_valid  = s.sv;
    mode       = s.md;
    bf_out_bus = s.bf;
    bf_valid   = s.bv;
    err_clr    = s.clr;
    @(posedge clk);
    #1;
    sel_bus    = '0;
    sel_mask   = '0;
    sel_valid  = 1'b0;
    mode       = 1'b0;
    bf_out_bus = '0;
    bf_valid   = 1'b0;
    err_clr    = 1'b0;
  endtask

  // Select beat, LAT-1 idle cycles, then the data slot; returns in the output cycle
  task automatic send_beat(input logic [LANES*SW-1:0] sel, input logic [LANES-1:0] mask,
                           input logic md, input logic [LANES*DW-1:0] bf, input logic bv,
                           input logic clr);
    stim_t s;
    s = '0; s.sel = sel; s.mask = mask; s.md = md; s.sv = 1'b1;
    apply(s);
    for (int c = 1; c < LAT; c++) apply('0);
    s = '0; s.bf = bf; s.bv = bv; s.clr = clr;
    apply(s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (d_in_bus !== '0) begin failures++; $display("FAIL reset_d_in got=%h want=0", d_in_bus); end
    checks++; if (we_bus !== '0) begin failures++; $display("FAIL reset_we got=%b want=0", we_bus); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%b want=0", d_valid); end
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL reset_align got=%b want=0", align_err); end
    checks++; if (conflict_err !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b want=0", conflict_err); end
    checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
    rst = 1'b0;
    exp_q.delete();
    exp_beats = 0;
    apply('0);
  endtask

  task automatic test_permute();
    stim_t s;
    beat_t e;
    s = '0; s.sel = {3'd0, 3'd1, 3'd2, 3'd3}; s.mask = 4'hF; s.sv = 1'b1;
    e.d = {16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD}; e.we = 4'hF;
    exp_q.push_back(e); exp_beats++;
    apply(s);
    for (int c = 1; c <= LAT; c++) begin
      checks++;
      if (d_valid !== 1'b0) begin failures++; $display("FAIL permute_early cycle=%0d d_valid=%b want=0", c, d_valid); end
      s = '0;
      if (c == LAT) begin s.bf = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}; s.bv = 1'b1; end
      apply(s);
    end
    checks++;
    if (d_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL permute_valid d_valid=%b want=1 queued=%0d", d_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      checks++; if (d_in_bus !== e.d) begin failures++; $display("FAIL permute_data got=%h want=%h", d_in_bus, e.d); end
      checks++; if (we_bus !== e.we) begin failures++; $display("FAIL permute_we got=%b want=%b", we_bus, e.we); end
    end
    checks++; if (beat_cnt !== 16'(exp_beats)) begin failures++; $display("FAIL permute_cnt got=%0d want=%0d", beat_cnt, exp_beats); end
    apply('0);
    checks++;
    if (d_valid !== 1'b0 || we_bus !== '0 || d_in_bus !== '0) begin
      failures++; $display("FAIL permute_idle d_valid=%b we=%b d_in=%h want all 0", d_valid, we_bus, d_in_bus);
    end
  endtask

  task automatic test_bypass();
    beat_t e;
    e.d = {16'h0000, 16'h3333, 16'h0000, 16'h1111}; e.we = 4'b0101;
    exp_q.push_back(e); exp_beats++;
    send_beat({3'd6, 3'd6, 3'd6, 3'd6}, 4'b0101, 1'b1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b0);
    checks++;
    if (d_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL bypass_valid d_valid=%b want=1", d_valid);
    end else begin
      e = exp_q.pop_front();
      checks++; if (d_in_bus !== e.d) begin failures++; $display("FAIL bypass_data got=%h want=%h", d_in_bus, e.d); end
      checks++; if (we_bus !== e.we) begin failures++; $display("FAIL bypass_we got=%b want=%b", we_bus, e.we); end
    end
    checks++;
    if (conflict_err !== 1'b0 || align_err !== 1'b0) begin
      failures++; $display("FAIL bypass_errors conflict=%b align=%b want 0 0", conflict_err, align_err);
    end
  endtask

  task automatic test_conflict();
    logic [LANES*SW-1:0] sel_t [4];
    logic [LANES-1:0]    msk_t [4];
    logic [LANES*DW-1:0] dex_t [4];
    logic [LANES-1:0]    wex_t [4];
    logic                clr_t [4];
    logic                cf_t  [4];
    logic                after_t [4];
    logic [LANES*DW-1:0] bf;
    beat_t               e;
    bf = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
    // shared source on lanes 0/1
    sel_t[0] = {3'd1, 3'd0, 3'd2, 3'd2}; msk_t[0] = 4'hF; clr_t[0] = 1'b0;
    dex_t[0] = {16'h0A01, 16'h0A00, 16'h0A02, 16'h0A02}; wex_t[0] = 4'hF; cf_t[0] = 1'b1; after_t[0] = 1'b1;
    // out-of-range select on lane 3
    sel_t[1] = {3'd5, 3'd2, 3'd1, 3'd0}; msk_t[1] = 4'hF; clr_t[1] = 1'b0;
    dex_t[1] = {16'h0000, 16'h0A02, 16'h0A01, 16'h0A00}; wex_t[1] = 4'b0111; cf_t[1] = 1'b1; after_t[1] = 1'b0;
    // new conflict in the same cycle as err_clr: flag stays set
    sel_t[2] = {3'd0, 3'd0, 3'd1, 3'd2}; msk_t[2] = 4'hF; clr_t[2] = 1'b1;
    dex_t[2] = {16'h0A00, 16'h0A00, 16'h0A01, 16'h0A02}; wex_t[2] = 4'hF; cf_t[2] = 1'b1; after_t[2] = 1'b1;
    // duplicates only on disabled lanes: no conflict
    sel_t[3] = {3'd0, 3'd0, 3'd1, 3'd0}; msk_t[3] = 4'b0011; clr_t[3] = 1'b0;
    dex_t[3] = {16'h0000, 16'h0000, 16'h0A01, 16'h0A00}; wex_t[3] = 4'b0011; cf_t[3] = 1'b0; after_t[3] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      e.d = dex_t[b]; e.we = wex_t[b];
      exp_q.push_back(e); exp_beats++;
      send_beat(sel_t[b], msk_t[b], 1'b0, bf, 1'b1, clr_t[b]);
      checks++;
      if (d_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++; $display("FAIL conflict_valid beat=%0d d_valid=%b want=1", b, d_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (d_in_bus !== e.d || we_bus !== e.we) begin
          failures++; $display("FAIL conflict_data beat=%0d got=%h/%b want=%h/%b", b, d_in_bus, we_bus, e.d, e.we);
        end
      end
      checks++;
      if (conflict_err !== cf_t[b]) begin failures++; $display("FAIL conflict_flag beat=%0d got=%b want=%b", b, conflict_err, cf_t[b]); end
      if (after_t[b]) begin
        stim_t s;
        s = '0; s.clr = 1'b1;
        apply(s);
        checks++;
        if (conflict_err !== 1'b0) begin failures++; $display("FAIL conflict_clear beat=%0d got=%b want=0", b, conflict_err); end
      end
    end
  endtask

  task automatic test_align();
    stim_t s;
    logic [15:0] cnt0;
    cnt0 = beat_cnt;
    send_beat({3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    checks++;
    if (d_valid !== 1'b0 || we_bus !== '0 || d_in_bus !== '0) begin
      failures++; $display("FAIL align_sel_only d_valid=%b we=%b d_in=%h want all 0", d_valid, we_bus, d_in_bus);
    end
    checks++; if (align_err !== 1'b1) begin failures++; $display("FAIL align_sel_flag got=%b want=1", align_err); end
    checks++; if (beat_cnt !== cnt0) begin failures++; $display("FAIL align_cnt got=%0d want=%0d", beat_cnt, cnt0); end
    s = '0; s.clr = 1'b1; apply(s);
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL align_clear got=%b want=0", align_err); end
    s = '0; s.bf = 64'hFFFF_0000_FFFF_0000; s.bv = 1'b1; apply(s);
    checks++;
    if (d_valid !== 1'b0 || align_err !== 1'b1 || d_in_bus !== '0) begin
      failures++; $display("FAIL align_bf_only d_valid=%b align=%b d_in=%h want 0 1 0", d_valid, align_err, d_in_bus);
    end
    s = '0; s.clr = 1'b1; apply(s);
    for (int c = 0; c < LAT + 2; c++) apply('0);
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL align_idle got=%b want=0", align_err); end
  endtask

  task automatic test_back_to_back();
    logic [LANES*SW-1:0] sel [4];
    logic [LANES-1:0]    msk [4];
    logic                md  [4];
    logic [LANES*DW-1:0] bf  [4];
    beat_t               e;
    stim_t               s;
    int                  seen;
    logic                want_v;
    for (int b = 0; b < 4; b++) begin
      sel[b] = 12'($urandom);
      msk[b] = 4'($urandom_range(1, 15));
      md[b]  = 1'($urandom_range(0, 1));
      bf[b]  = {$urandom, $urandom};
    end
    seen = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      s = '0;
      if (c < 4) begin
        s.sel = sel[c]; s.mask = msk[c]; s.md = md[c]; s.sv = 1'b1;
        exp_q.push_back(model(sel[c], msk[c], md[c], bf[c])); exp_beats++;
      end
      if (c >= LAT && c < LAT + 4) begin s.bf = bf[c-LAT]; s.bv = 1'b1; end
      apply(s);
      want_v = (c + 1 >= LAT + 1) && (c + 1 <= LAT + 4);
      checks++;
      if (d_valid !== want_v) begin failures++; $display("FAIL b2b_timing cycle=%0d d_valid=%b want=%b", c + 1, d_valid, want_v); end
      if (d_valid === 1'b1) begin
        seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL b2b_unexpected cycle=%0d got beat want none", c + 1);
        end else begin
          e = exp_q.pop_front();
          if (d_in_bus !== e.d || we_bus !== e.we) begin
            failures++; $display("FAIL b2b_data beat=%0d got=%h/%b want=%h/%b", seen, d_in_bus, we_bus, e.d, e.we);
          end
        end
      end
    end
    checks++; if (seen != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", seen); end
    checks++; if (beat_cnt !== 16'(exp_beats)) begin failures++; $display("FAIL b2b_cnt got=%0d want=%0d", beat_cnt, exp_beats); end
  endtask

  task automatic test_reset_midstream();
    stim_t s;
    beat_t e;
    for (int c = 0; c <= LAT + 1; c++) begin
      s = '0;
      if (c < 4) begin s.sel = {3'd0, 3'd1, 3'd2, 3'd3}; s.mask = 4'hF; s.sv = 1'b1; end
      if (c >= LAT) begin s.bf = {$urandom, $urandom}; s.bv = 1'b1; end
      apply(s);
    end
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL midrst_beat2 d_valid=%b want=1", d_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (d_valid !== 1'b0 || we_bus !== '0 || d_in_bus !== '0 || beat_cnt !== 16'd0) begin
      failures++; $display("FAIL midrst_clear d_valid=%b we=%b d_in=%h cnt=%0d want all 0", d_valid, we_bus, d_in_bus, beat_cnt);
    end
    exp_q.delete();
    exp_beats = 0;
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = LAT + 2; c < LAT + 7; c++) begin
      s = '0;
      if (c < LAT + 4) begin s.bf = {$urandom, $urandom}; s.bv = 1'b1; end
      apply(s);
      checks++;
      if (d_valid !== 1'b0) begin failures++; $display("FAIL midrst_inflight cycle=%0d d_valid=%b want=0", c, d_valid); end
    end
    s = '0; s.clr = 1'b1; apply(s);
    e.d = {16'h4444, 16'h3333, 16'h2222, 16'h1111}; e.we = 4'hF;
    exp_q.push_back(e); exp_beats++;
    send_beat('0, 4'hF, 1'b1, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b0);
    checks++;
    if (d_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++; $display("FAIL midrst_fresh d_valid=%b want=1", d_valid);
    end else begin
      e = exp_q.pop_front();
      if (d_in_bus !== e.d || beat_cnt !== 16'd1) begin
        failures++; $display("FAIL midrst_fresh_data got=%h cnt=%0d want=%h cnt=1", d_in_bus, beat_cnt, e.d);
      end
    end
  endtask

  task automatic test_wrap();
    int seen;
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    exp_beats = 0;
    seen = 0;
    sel_mask = 4'hF;
    mode     = 1'b1;
    for (int c = 0; c < 65536 + LAT; c++) begin
      sel_valid  = (c < 65536);
      bf_valid   = (c >= LAT);
      bf_out_bus = {4{16'(c)}};
      @(posedge clk);
      #1;
      if (d_valid === 1'b1) begin
        seen++;
        if (seen == 65535) begin
          checks++;
          if (beat_cnt !== 16'hFFFF) begin failures++; $display("FAIL wrap_max got=%h want=ffff", beat_cnt); end
        end
      end
    end
    sel_valid = 1'b0; bf_valid = 1'b0; sel_mask = '0; mode = 1'b0; bf_out_bus = '0;
    checks++; if (seen != 65536) begin failures++; $display("FAIL wrap_seen got=%0d want=65536", seen); end
    checks++; if (beat_cnt !== 16'd0) begin failures++; $display("FAIL wrap_cnt got=%0d want=0", beat_cnt); end
    checks++; if (align_err !== 1'b0) begin failures++; $display("FAIL wrap_align got=%b want=0", align_err); end
  endtask

  initial begin
    #1;
    test_reset();
    test_permute();
    test_bypass();
    test_conflict();
    test_align();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
